ex_mul_unit: RTL and testbench



---
 rtl/ex_mul_unit.sv | 107 ++++++++++
 tb/tb_ex_mul_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier for the EX stage (mul, low WIDTH bits).
// Holds the pipeline through stall_o while iterating; pulses valid_o once.
module ex_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic [4:0]       rd_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    cnt;
    logic [4:0]       rd_q;
    logic             accept;
    logic             last;

    // A new mul is taken from IDLE or DONE, never while iterating.
    assign accept  = start_i & ~flush_i & (state != BUSY);
    assign last    = (state == BUSY) & (cnt == CW'(WIDTH - 1));
    assign acc_nx  = mplier[0] ? acc + mcand : acc;
    assign stall_o = (state == BUSY) | accept;

    // Next-state logic; flush overrides start and completion.
    always_comb begin
        state_nx = state;
        if (flush_i) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nx = BUSY;
                BUSY: if (last) state_nx = DONE;
                DONE: state_nx = accept ? BUSY : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_o <= (state_nx == BUSY);
        end
    end

    // Operand load, one shift-add step per cycle, and result capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            rd_q     <= '0;
            valid_o  <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                cnt <= '0;
            end else if (accept) begin
                acc    <= '0;
                mcand  <= rs1_data_i;
                mplier <= rs2_data_i;
                rd_q   <= rd_i;
                cnt    <= '0;
            end else if (state == BUSY) begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    result_o <= acc_nx;
                    rd_o     <= rd_q;
                    valid_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed testbench for ex_mul_unit with hand-computed products.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_ex_mul_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        busy;
    logic        stall;
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;
    int edges;
    int bad_stall;
    int seen_valid;

    ex_mul_unit #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .flush_i   (flush),
        .rs1_data_i(rs1),
        .rs2_data_i(rs2),
        .rd_i      (rd_in),
        .busy_o    (busy),
        .stall_o   (stall),
        .valid_o   (valid),
        .result_o  (result),
        .rd_o      (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul, wait for valid (bounded) and check latency,
    // continuous stall, product and destination register.
    task automatic do_mul(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          input logic [31:0] exp);
        rs1 = a;
        rs2 = b;
        rd_in = r;
        start = 1'b1;
        #1;
        chk({tag, "_req_stall"}, stall, 1);
        step();
        start = 1'b0;
        edges = 0;
        bad_stall = 0;
        while (!valid && edges < 40) begin
            if (!stall) bad_stall++;
            step();
            edges++;
        end
        chk({tag, "_latency"}, edges, 32);
        chk({tag, "_stall_gap"}, bad_stall, 0);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_rd"}, rd_out, r);
        chk({tag, "_done_stall"}, stall, 0);
        step();
        chk({tag, "_valid_fall"}, valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_result", result, 0);
        chk("rst_rd", rd_out, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        step();

        do_mul("basic", 32'd3, 32'd5, 5'd7, 32'd15);
        do_mul("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h1);
        do_mul("msb", 32'h8000_0000, 32'd2, 5'd2, 32'h0);
        do_mul("neg", 32'hFFFF_FFFE, 32'd3, 5'd31, 32'hFFFF_FFFA);

        // Flush at BUSY cycle 10: no pulse, result keeps 0xFFFFFFFA.
        rs1 = 32'd6;
        rs2 = 32'd7;
        rd_in = 5'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("fl_busy_before", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_busy", busy, 0);
        chk("fl_stall", stall, 0);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) seen_valid++;
            step();
        end
        chk("fl_no_valid", seen_valid, 0);
        chk("fl_result", result, 32'hFFFF_FFFA);
        chk("fl_rd", rd_out, 31);

        // Flush on the completion edge.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 31; i++) step();
        chk("flc_busy_before", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flc_valid", valid, 0);
        chk("flc_result", result, 32'hFFFF_FFFA);
        chk("flc_busy", busy, 0);
        step();
        chk("flc_valid_late", valid, 0);

        // Back-to-back: second start during the DONE cycle.
        rs1 = 32'd2;
        rs2 = 32'd9;
        rd_in = 5'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        while (!valid && edges < 40) begin
            step();
            edges++;
        end
        chk("b2b_lat1", edges, 32);
        chk("b2b_res1", result, 18);
        rs1 = 32'd4;
        rs2 = 32'd4;
        rd_in = 5'd4;
        start = 1'b1;
        #1;
        chk("b2b_done_stall", stall, 1);
        step();
        start = 1'b0;
        chk("b2b_valid_fall", valid, 0);
        edges = 0;
        bad_stall = 0;
        while (!valid && edges < 40) begin
            if (!stall) bad_stall++;
            step();
            edges++;
        end
        chk("b2b_lat2", edges, 32);
        chk("b2b_stall_gap", bad_stall, 0);
        chk("b2b_res2", result, 16);
        chk("b2b_rd2", rd_out, 4);
        step();

        // Start and operands toggle while busy; original product wins.
        rs1 = 32'd5;
        rs2 = 32'd7;
        rd_in = 5'd9;
        start = 1'b1;
        step();
        edges = 0;
        while (!valid && edges < 40) begin
            start = 1'($urandom_range(0, 1));
            rs1 = $urandom;
            rs2 = $urandom;
            rd_in = 5'($urandom);
            step();
            edges++;
        end
        start = 1'b0;
        chk("ign_latency", edges, 32);
        chk("ign_result", result, 35);
        chk("ign_rd", rd_out, 9);
        step();
        chk("ign_idle", busy, 0);

        // Asynchronous reset at BUSY cycle 5.
        rs1 = 32'd8;
        rs2 = 32'd8;
        rd_in = 5'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_result", result, 0);
        chk("mrst_rd", rd_out, 0);
        chk("mrst_stall", stall, 0);
        #10;
        rst = 1'b0;
        step();
        do_mul("post_rst", 32'd10, 32'd10, 5'd11, 32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
